// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared state/region types and wait-state helper for the memory bus responder
package mem_bus_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REGION_ROM = 2'd0,
    REGION_RAM = 2'd1,
    REGION_IO  = 2'd2
  } region_t;

  // Wait-state count loaded into the access counter for a decoded region.
  function automatic logic [CNT_W-1:0] region_wait(
    input region_t          region,
    input logic [CNT_W-1:0] rom_wait,
    input logic [CNT_W-1:0] ram_wait,
    input logic [CNT_W-1:0] io_wait
  );
    case (region)
      REGION_ROM: region_wait = rom_wait;
      REGION_RAM: region_wait = ram_wait;
      default:    region_wait = io_wait;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - CPU request bus plus memory/peripheral side signals
interface mem_bus_responder_if;
  import mem_bus_responder_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] dout;
  logic              rdy;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rom_cs;
  logic              ram_cs;
  logic              io_cs;
  logic              mem_we;
  logic [DATA_W-1:0] rom_rdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] io_rdata;

  // CPU core plus the memories it reaches through the responder
  modport master (
    output addr, din, rd, wr, rom_rdata, ram_rdata, io_rdata,
    input  dout, rdy, err, mem_addr, mem_wdata, rom_cs, ram_cs, io_cs, mem_we
  );

  // The responder itself
  modport slave (
    input  addr, din, rd, wr, rom_rdata, ram_rdata, io_rdata,
    output dout, rdy, err, mem_addr, mem_wdata, rom_cs, ram_cs, io_cs, mem_we
  );

endinterface

// File: rtl/mem_bus_responder_region_decoder.sv
// rtl/mem_bus_responder_region_decoder.sv - combinational address to ROM/RAM/IO region decode
module mem_bus_responder_region_decoder
  import mem_bus_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROM_TOP = 16'h1FFF,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region
);

  // ROM wins at the low end, I/O at the top, everything between is RAM
  always_comb begin
    region = REGION_RAM;
    if (addr <= ROM_TOP) begin
      region = REGION_ROM;
    end else if (addr >= IO_BASE) begin
      region = REGION_IO;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder with per-region wait states and request/ready handshake
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROM_TOP  = 16'h1FFF,
  parameter logic [ADDR_W-1:0] IO_BASE  = 16'hFF00,
  parameter int unsigned       ROM_WAIT = 2,
  parameter int unsigned       RAM_WAIT = 0,
  parameter int unsigned       IO_WAIT  = 3
) (
  input logic              clk,
  input logic              reset_n,
  mem_bus_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] ROM_W = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_W = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_W  = CNT_W'(IO_WAIT);

  state_t           state;
  state_t           state_next;
  region_t          addr_region;
  region_t          region_q;
  logic             write_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             reject;
  logic             finish;

  mem_bus_responder_region_decoder #(
    .ROM_TOP (ROM_TOP),
    .IO_BASE (IO_BASE)
  ) u_decoder (
    .addr   (bus.addr),
    .region (addr_region)
  );

  // State register; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, datapath strobes and the combinational bus outputs
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    reject      = 1'b0;
    finish      = 1'b0;
    bus.rdy     = 1'b0;
    bus.rom_cs  = 1'b0;
    bus.ram_cs  = 1'b0;
    bus.io_cs   = 1'b0;
    bus.mem_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rd && bus.wr) begin
          reject     = 1'b1;
          state_next = ST_DONE;
        end else if (bus.wr && addr_region == REGION_ROM) begin
          reject     = 1'b1;
          state_next = ST_DONE;
        end else if (bus.rd || bus.wr) begin
          accept     = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.rom_cs = (region_q == REGION_ROM);
        bus.ram_cs = (region_q == REGION_RAM);
        bus.io_cs  = (region_q == REGION_IO);
        if (cnt == '0) begin
          finish     = 1'b1;
          bus.mem_we = write_q;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.rdy    = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        // The CPU must drop both strobes before another request is taken
        if (!bus.rd && !bus.wr) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latched request, wait counter, read data and error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.dout      <= '0;
      bus.err       <= 1'b0;
      region_q      <= REGION_ROM;
      write_q       <= 1'b0;
      cnt           <= '0;
    end else begin
      if (accept) begin
        bus.mem_addr  <= bus.addr;
        bus.mem_wdata <= bus.din;
        region_q      <= addr_region;
        write_q       <= bus.wr;
        cnt           <= region_wait(addr_region, ROM_W, RAM_W, IO_W);
        bus.err       <= 1'b0;
      end
      if (reject) begin
        bus.err <= 1'b1;
      end
      if (state == ST_ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish && !write_q) begin
        case (region_q)
          REGION_ROM: bus.dout <= bus.rom_rdata;
          REGION_RAM: bus.dout <= bus.ram_rdata;
          default:    bus.dout <= bus.io_rdata;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU address bus: samples the muxed address, write data and read/write strobes driven by the CPU core, decodes the address into ROM, RAM or I/O regions, and runs the access with per-region wait states. Returns read data and a one-cycle ready pulse under a four-phase request/ready handshake. Sits between the CPU datapath and the on-chip ROM, RAM and peripheral blocks.

## Interface
Parameters:
- ROM_TOP, 16'h1FFF, last ROM address; ROM is 0..ROM_TOP.
- IO_BASE, 16'hFF00, first I/O address; I/O is IO_BASE..16'hFFFF; RAM is ROM_TOP+1..IO_BASE-1.
- ROM_WAIT, 2, extra wait cycles for ROM accesses (0..15).
- RAM_WAIT, 0, extra wait cycles for RAM accesses (0..15).
- IO_WAIT, 3, extra wait cycles for I/O accesses (0..15).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- ADDR  in  16  CPU bus address.
- DIN  in  16  CPU write data.
- RD  in  1  read request, level, held until RDY seen.
- WR  in  1  write request, level, held until RDY seen.
- DOUT  out  16  read data returned to CPU.
- RDY  out  1  one-cycle completion pulse.
- ERR  out  1  error flag for the completed request.
- MEM_ADDR  out  16  latched address to memories/peripherals.
- MEM_WDATA  out  16  latched write data.
- ROM_CS, RAM_CS, IO_CS  out  1 each  region selects.
- MEM_WE  out  1  write enable.
- ROM_RDATA, RAM_RDATA, IO_RDATA  in  16 each  region read data.

## Operation
- States: IDLE, ACCESS, DONE, HOLD.
- IDLE: if RD xor WR high, latch ADDR→MEM_ADDR, DIN→MEM_WDATA, region, direction; load wait counter with region wait; clear ERR; go ACCESS.
- IDLE, RD and WR both high: no access, ERR←1, go DONE.
- IDLE, WR to ROM region: no CS, no WE, ERR←1, go DONE.
- ACCESS: selected CS high every cycle; counter decrements; at counter==0: reads capture region RDATA into DOUT, writes assert MEM_WE this cycle only; go DONE.
- DONE: RDY=1 for exactly this cycle; CS and WE low; go HOLD.
- HOLD: wait until RD=0 and WR=0, then IDLE. No new request is accepted before both drop.
- DOUT holds last read value; unchanged by writes or errors. ERR holds until next accepted request.
- ADDR/DIN changes after acceptance are ignored (latched values drive the access).

## Timing
- Reset (RESET_N low at an edge): state IDLE; DOUT, MEM_ADDR, MEM_WDATA = 0; RDY, ERR, all CS, MEM_WE = 0. Reset mid-access aborts it; CS/WE low from the next edge, no RDY issued.
- Request sampled high in IDLE at edge t: ACCESS occupies cycles t+1..t+N+1 (N = region wait); RDY high in cycle t+N+2; DOUT valid from the same cycle.
- RAM with RAM_WAIT=0: RDY two cycles after request sampled.
- Error cases: RDY one cycle after request sampled, ERR valid with RDY.
- Minimum request-to-request spacing: RDY cycle + one HOLD cycle with requests low.
- Wait counter 4 bits; region decode uses unsigned 16-bit compares; boundary addresses ROM_TOP, ROM_TOP+1, IO_BASE-1, IO_BASE map as defined above.

## Structure
- State encodings and region codes (REGION_ROM/RAM/IO) as `define entries in the shared constants.v, alongside the existing bus select constants.
- One sub-module: mem_region_decoder (combinational ADDR → region code, parameterised by ROM_TOP/IO_BASE). Counter and FSM stay in the top.

## Test plan
- RAM read 16'h4000, RAM_RDATA=16'hBEEF, RAM_WAIT=0 -> RAM_CS high 1 cycle, RDY 2 cycles after RD sampled, DOUT=16'hBEEF, ERR=0.
- ROM read 16'h1FFF, ROM_WAIT=2 -> ROM_CS high 3 cycles, RDY at t+4; read 16'h2000 -> RAM_CS instead.
- I/O write 16'hFF00 data 16'h00A5, IO_WAIT=3 -> IO_CS 4 cycles, MEM_WE only in 4th, MEM_WDATA=16'h00A5, DOUT unchanged.
- Write 16'h0010 (ROM) -> no CS/WE, RDY+ERR at t+1; RD and WR together -> same response.
- RD held high after RDY -> no second access until RD drops; next RD accepted one cycle after drop.
- RESET_N low during ROM ACCESS -> CS low next edge, no RDY, all outputs 0; fresh RAM read afterwards completes normally.
